alu_share_arbiter: RTL and testbench

Two-requester arbiter and response buffer in front of the shared 32-bit combinational ALU. It accepts operation requests from the execute stage (requester 0) and the branch/compare unit (requester 1) over valid/ready handshakes. Each cycle it grants at most one request using round-robin priority and drives the ALU with that request. It registers the ALU result and flags into a single response slot, which is held until the owning requester takes it.

---
 rtl/alu_ctrl_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 19 +
 rtl/alu_share_arbiter.sv | 105 ++++++++++
 tb/tb_alu_share_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared ALU op codes, datapath width and response-slot state
package alu_ctrl_pkg;
    localparam int ALU_W = 32;
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_COMP = 4'b0001;
    localparam logic [3:0] OP_DIFF = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SRLV = 4'b1000;
    localparam logic [3:0] OP_SLLV = 4'b1001;
    localparam logic [3:0] OP_SRAV = 4'b1010;
    localparam logic [3:0] OP_LAST = OP_SRAV;
    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_e;
    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_LAST;
    endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter producing a one-hot grant when enabled
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_grant
);
    logic r_prio;
    // Single requester wins outright; on contention the prio side wins
    always_comb begin
        o_grant = !i_en ? 2'b00 : (&i_req) ? (r_prio ? 2'b10 : 2'b01) : i_req;
    end
    // After a grant the other requester gets priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_prio <= 1'b0;
        else if (|o_grant) r_prio <= o_grant[0];
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU with a one-entry response slot
module alu_share_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = ALU_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*4-1:0] req_op,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*5-1:0] req_shamt,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W-1:0]      rsp_result,
    output logic              rsp_negative,
    output logic              rsp_zero,
    output logic              rsp_carry,
    output logic              rsp_illegal,
    output logic [W-1:0]      alu_in1,
    output logic [W-1:0]      alu_in2,
    output logic [4:0]        alu_shamt,
    output logic [3:0]        alu_ctrl,
    input  logic [W-1:0]      alu_out,
    input  logic              alu_negative,
    input  logic              alu_zero,
    input  logic              alu_carry
);
    slot_e r_slot, w_slot_next;
    logic r_owner, w_owner_next;
    logic w_can_accept, w_any, w_g, w_illegal, w_unused;
    logic [1:0] w_grant;

    // Flags are derived from alu_out directly; the ALU's own N/Z are not needed
    assign w_unused = alu_negative ^ alu_zero;

    // Gating with rst_n keeps req_ready low for the whole reset period
    assign w_can_accept = rst_n && (r_slot == SLOT_EMPTY || rsp_ready[r_owner]);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (req_valid),
        .i_en    (w_can_accept),
        .o_grant (w_grant)
    );

    assign w_any     = |w_grant;
    assign w_g       = w_grant[1];
    assign req_ready = w_grant;
    assign w_illegal = is_illegal(alu_ctrl);

    // Drive the ALU from the granted requester, all-zero when idle
    always_comb begin
        alu_ctrl  = !w_any ? '0 : w_g ? req_op[7:4]        : req_op[3:0];
        alu_in1   = !w_any ? '0 : w_g ? req_a[2*W-1:W]     : req_a[W-1:0];
        alu_in2   = !w_any ? '0 : w_g ? req_b[2*W-1:W]     : req_b[W-1:0];
        alu_shamt = !w_any ? '0 : w_g ? req_shamt[9:5]     : req_shamt[4:0];
    end

    // Slot fills on any grant; drains only when the owner consumes without a refill
    always_comb begin
        w_slot_next  = r_slot;
        w_owner_next = r_owner;
        if (w_any) begin
            w_slot_next  = SLOT_FULL;
            w_owner_next = w_g;
        end else if (r_slot == SLOT_FULL && rsp_ready[r_owner]) begin
            w_slot_next = SLOT_EMPTY;
        end
    end

    // Slot state register; reset discards any buffered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot  <= SLOT_EMPTY;
            r_owner <= 1'b0;
        end else begin
            r_slot  <= w_slot_next;
            r_owner <= w_owner_next;
        end
    end

    // Capture result and flags in the grant cycle; illegal ops report a forced zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result   <= '0;
            rsp_negative <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_carry    <= 1'b0;
            rsp_illegal  <= 1'b0;
        end else if (w_any) begin
            rsp_result   <= w_illegal ? '0 : alu_out;
            rsp_negative <= !w_illegal && alu_out[W-1];
            rsp_zero     <= w_illegal || alu_out == '0;
            rsp_carry    <= alu_ctrl == OP_ADD && alu_carry;
            rsp_illegal  <= w_illegal;
        end
    end

    assign rsp_valid = {r_slot == SLOT_FULL && r_owner, r_slot == SLOT_FULL && !r_owner};
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of arbitration, response slot, flags and reset
module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [7:0]  req_op;
    logic [63:0] req_a, req_b;
    logic [9:0]  req_shamt;
    logic [31:0] rsp_result, alu_in1, alu_in2, alu_out;
    logic        rsp_negative, rsp_zero, rsp_carry, rsp_illegal;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_ctrl;
    logic        alu_negative, alu_zero, alu_carry;
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_negative(rsp_negative), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
        .rsp_illegal(rsp_illegal), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_shamt(alu_shamt), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
        .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_carry(alu_carry)
    );

    // Small ALU model; unknown codes return a marker so forced-zero results are visible
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_out = alu_in1 + alu_in2;
            4'b0010: alu_out = alu_in1 - alu_in2;
            4'b0011: alu_out = alu_in1 & alu_in2;
            4'b0100: alu_out = alu_in1 ^ alu_in2;
            4'b0111: alu_out = $signed(alu_in1) >>> alu_shamt;
            default: alu_out = 32'hDEADBEEF;
        endcase
        alu_carry    = ({1'b0, alu_in1} + {1'b0, alu_in2}) >> 32 != 33'd0;
        alu_negative = alu_out[31];
        alu_zero     = alu_out == 32'd0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic [1:0] v, input logic [31:0] r,
                             input logic n, input logic z, input logic c, input logic il);
        check({tag, ".valid"}, {30'd0, rsp_valid}, {30'd0, v});
        check({tag, ".result"}, rsp_result, r);
        check({tag, ".flags"}, {28'd0, rsp_negative, rsp_zero, rsp_carry, rsp_illegal},
              {28'd0, n, z, c, il});
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        req_shamt = '0;
        #12;
        check("reset.req_ready", {30'd0, req_ready}, 32'd0);
        check_rsp("reset", 2'b00, 32'd0, 0, 0, 0, 0);
        rst_n = 1'b1;
        req_valid = 2'b00;
        #1;
        check("idle.alu_ctrl", {28'd0, alu_ctrl}, 32'd0);

        // single ADD from requester 0
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        req_a = {32'd0, 32'd5};
        req_b = {32'd0, 32'd7};
        #1;
        check("add.req_ready", {30'd0, req_ready}, 32'd1);
        check("add.alu_in1", alu_in1, 32'd5);
        check("add.alu_in2", alu_in2, 32'd7);
        tick();
        check_rsp("add", 2'b01, 32'd12, 0, 0, 0, 0);
        req_valid = 2'b00;
        #1;
        check("nogrant.alu_in1", alu_in1, 32'd0);
        tick();
        check("drain.valid", {30'd0, rsp_valid}, 32'd0);

        // prio now 1: contention grants requester 1 (ADD overflow)
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req_op = {4'b0000, 4'b0111};
        req_a = {32'hFFFFFFFF, 32'h80000000};
        req_b = {32'h00000001, 32'h80000000};
        req_shamt = {5'd0, 5'd4};
        #1;
        check("ovf.req_ready", {30'd0, req_ready}, 32'd2);
        tick();
        check_rsp("ovf", 2'b10, 32'd0, 0, 1, 1, 0);

        // backpressure: three stalled cycles, then a non-owner rsp_ready
        for (int i = 0; i < 4; i++) begin
            rsp_ready = (i == 3) ? 2'b01 : 2'b00;
            #1;
            check("stall.req_ready", {30'd0, req_ready}, 32'd0);
            tick();
            check_rsp("stall", 2'b10, 32'd0, 0, 1, 1, 0);
        end
        rsp_ready = 2'b10;
        #1;
        check("release.req_ready", {30'd0, req_ready}, 32'd1);
        tick();
        check_rsp("sra", 2'b01, 32'hF8000000, 1, 0, 0, 0);

        // illegal op from requester 0
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        req_op = {4'b0000, 4'b1100};
        req_a = {32'd0, 32'd5};
        req_b = {32'd0, 32'd3};
        #1;
        check("illegal.alu_ctrl", {28'd0, alu_ctrl}, 32'hC);
        tick();
        check_rsp("illegal", 2'b01, 32'd0, 0, 1, 0, 1);

        // fill FULL(1) with AND, then reset asynchronously
        req_valid = 2'b10;
        req_op = {4'b0011, 4'b0000};
        req_a = {32'h0000F0F0, 32'd0};
        req_b = {32'h0000FF00, 32'd0};
        tick();
        check_rsp("and", 2'b10, 32'h0000F000, 0, 0, 0, 0);
        rsp_ready = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        check_rsp("async_reset", 2'b00, 32'd0, 0, 0, 0, 0);
        check("async_reset.req_ready", {30'd0, req_ready}, 32'd0);
        tick();
        check("held_reset.valid", {30'd0, rsp_valid}, 32'd0);

        // after reset both valid: 0,1,0,1 with one response per cycle
        rst_n = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        req_op = {4'b0100, 4'b0000};
        req_a = {32'h000000FF, 32'd1};
        req_b = {32'h0000000F, 32'd2};
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr.req_ready", {30'd0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            if (i % 2 == 0) check_rsp("rr0", 2'b01, 32'd3, 0, 0, 0, 0);
            else check_rsp("rr1", 2'b10, 32'h000000F0, 0, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
